// File: rtl/io_bridge_pkg.sv
// Shared defaults for the I/O port bridge: word width, channel counts, FIFO depth
// and the channel-select width helper used by the top-level port list.
package io_bridge_pkg;

    localparam int DEF_NUBITS = 32;
    localparam int DEF_NUIOIN = 8;
    localparam int DEF_NUIOOU = 8;
    localparam int DEF_FDEPTH = 4;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; the head is visible
// combinationally while the FIFO is non-empty.
module io_fifo #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [NBITS-1:0]         din,
    output logic [NBITS-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [NBITS-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign count = r_wptr - r_rptr;
    assign head  = r_mem[r_rptr[AW-1:0]];

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_bridge.sv
// Peripheral-side responder for the core's I/O port bus: buffered input and
// output channels, a masked empty-to-data interrupt pulse and sticky error flags.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int NUBITS = DEF_NUBITS,
    parameter int NUIOIN = DEF_NUIOIN,
    parameter int NUIOOU = DEF_NUIOOU,
    parameter int FDEPTH = DEF_FDEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_in,
    input  logic [addr_w(NUIOIN)-1:0]   addr_in,
    output logic [NUBITS-1:0]           io_in,
    input  logic                        out_en,
    input  logic [addr_w(NUIOOU)-1:0]   addr_out,
    input  logic [NUBITS-1:0]           data_out,
    input  logic [NUIOIN*NUBITS-1:0]    in_data,
    input  logic [NUIOIN-1:0]           in_valid,
    output logic [NUIOIN-1:0]           in_ready,
    output logic [NUIOOU*NUBITS-1:0]    out_data,
    output logic [NUIOOU-1:0]           out_valid,
    input  logic [NUIOOU-1:0]           out_ready,
    input  logic [NUIOIN-1:0]           itr_mask,
    output logic                        itr,
    input  logic                        sts_clr,
    output logic [NUIOIN-1:0]           underrun,
    output logic [NUIOOU-1:0]           overrun
);

    localparam int AIN = addr_w(NUIOIN);
    localparam int AOU = addr_w(NUIOOU);
    localparam int FAW = $clog2(FDEPTH);

    logic [NUBITS-1:0] w_in_head [NUIOIN];
    logic [FAW:0]      w_in_cnt  [NUIOIN];
    logic [NUIOIN-1:0] w_in_empty, w_in_full, w_in_push, w_in_pop, w_in_rise, w_udr_set;

    logic [FAW:0]      w_out_cnt [NUIOOU];
    logic [NUIOOU-1:0] w_out_empty, w_out_full, w_out_sel, w_out_pop, w_ovr_set;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              r_itr;
    logic [NUIOIN-1:0] r_underrun;
    logic [NUIOOU-1:0] r_overrun;

    assign w_rd_ok = ({1'b0, addr_in}  < (AIN+1)'(NUIOIN));
    assign w_wr_ok = ({1'b0, addr_out} < (AOU+1)'(NUIOOU));

    // Readiness reflects pre-edge fullness only, keeping req_in off the in_ready path.
    assign in_ready = ~w_in_full & {NUIOIN{rst}};

    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
        assign w_in_push[gi] = in_valid[gi] & in_ready[gi];
        assign w_in_pop[gi]  = req_in & w_rd_ok & (addr_in == AIN'(gi)) & ~w_in_empty[gi];
        assign w_udr_set[gi] = req_in & w_rd_ok & (addr_in == AIN'(gi)) &  w_in_empty[gi];
        assign w_in_rise[gi] = itr_mask[gi] & w_in_push[gi] & (w_in_cnt[gi] == '0);

        io_fifo #(.NBITS(NUBITS), .DEPTH(FDEPTH)) u_in_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_in_push[gi]),
            .pop   (w_in_pop[gi]),
            .din   (in_data[gi*NUBITS +: NUBITS]),
            .head  (w_in_head[gi]),
            .empty (w_in_empty[gi]),
            .full  (w_in_full[gi]),
            .count (w_in_cnt[gi])
        );
    end

    for (genvar gi = 0; gi < NUIOOU; gi++) begin : g_out
        assign w_out_sel[gi] = out_en & w_wr_ok & (addr_out == AOU'(gi));
        assign w_out_pop[gi] = out_ready[gi] & ~w_out_empty[gi];
        assign w_ovr_set[gi] = w_out_sel[gi] & w_out_full[gi] & ~w_out_pop[gi];
        assign out_valid[gi] = (w_out_cnt[gi] != '0);

        io_fifo #(.NBITS(NUBITS), .DEPTH(FDEPTH)) u_out_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_out_sel[gi]),
            .pop   (w_out_pop[gi]),
            .din   (data_out),
            .head  (out_data[gi*NUBITS +: NUBITS]),
            .empty (w_out_empty[gi]),
            .full  (w_out_full[gi]),
            .count (w_out_cnt[gi])
        );
    end

    // w_in_pop is one-hot, so an OR-style mux is enough.
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (w_in_pop[k]) io_in = w_in_head[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_itr      <= 1'b0;
            r_underrun <= '0;
            r_overrun  <= '0;
        end else begin
            r_itr      <= |w_in_rise;
            r_underrun <= (sts_clr ? '0 : r_underrun) | w_udr_set;
            r_overrun  <= (sts_clr ? '0 : r_overrun)  | w_ovr_set;
        end
    end

    assign itr      = r_itr;
    assign underrun = r_underrun;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: per-channel queues predict read data, output
// order and sticky flags; one line printed per checked transaction.
module tb_io_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_in;
    logic [2:0]   addr_in;
    logic [31:0]  io_in;
    logic         out_en;
    logic [2:0]   addr_out;
    logic [31:0]  data_out;
    logic [255:0] in_data;
    logic [7:0]   in_valid;
    logic [7:0]   in_ready;
    logic [255:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [7:0]   itr_mask;
    logic         itr;
    logic         sts_clr;
    logic [7:0]   underrun;
    logic [7:0]   overrun;

    int errors = 0;
    int checks = 0;

    logic [31:0] in_q  [8][$];
    logic [31:0] out_q [8][$];
    logic [7:0]  exp_underrun = '0;
    logic [7:0]  exp_overrun  = '0;

    io_bridge dut (
        .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .itr_mask(itr_mask), .itr(itr), .sts_clr(sts_clr),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input int ch, input logic [31:0] d);
        in_data[ch*32 +: 32] = d;
        in_valid[ch] = 1'b1;
        if (in_q[ch].size() < 4) in_q[ch].push_back(d);
        tick();
        in_valid[ch] = 1'b0;
    endtask

    task automatic core_read(input int ch, output logic [31:0] d);
        req_in  = 1'b1;
        addr_in = 3'(ch);
        #1;
        d = io_in;
        tick();
        req_in = 1'b0;
    endtask

    task automatic write_out(input int ch, input logic [31:0] d);
        out_en   = 1'b1;
        addr_out = 3'(ch);
        data_out = d;
        if (out_q[ch].size() < 4) out_q[ch].push_back(d);
        else exp_overrun[ch] = 1'b1;
        tick();
        out_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = '1;
        in_data = {8{32'hCAFE_0001}};
        req_in = 1'b1;
        addr_in = 3'd0;
        repeat (3) tick();
        checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL rst_in_ready: got %h expected 00", in_ready); end
        checks++; if (io_in !== 32'h0) begin errors++; $display("FAIL rst_io_in: got %h expected 0", io_in); end
        checks++; if ({itr, underrun, overrun, out_valid} !== 25'h0) begin errors++;
            $display("FAIL rst_outputs: got itr=%b udr=%h ovr=%h ov=%h expected all 0", itr, underrun, overrun, out_valid); end
        in_valid = '0;
        req_in = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 8'hFF) begin errors++; $display("FAIL rel_in_ready: got %h expected ff", in_ready); end
        $display("reset: in_ready=%h io_in=%h", in_ready, io_in);
    endtask

    task automatic test_in_flow();
        push_in(2, 32'hA5);
        checks++; if (in_ready[2] !== 1'b1) begin errors++; $display("FAIL t1_ready2: got %b expected 1", in_ready[2]); end
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL t1_itr_unmasked: got %b expected 0", itr); end
        $display("push ch2 a5: in_ready=%h", in_ready);
    endtask

    task automatic test_read();
        logic [31:0] d, exp;
        exp = in_q[2].pop_front();
        core_read(2, d);
        checks++; if (d !== exp) begin errors++; $display("FAIL t2_read_ch2: got %h expected %h", d, exp); end
        $display("read ch2: %h", d);
        push_in(3, 32'h11);
        push_in(3, 32'h22);
        for (int i = 0; i < 2; i++) begin
            exp = in_q[3].pop_front();
            core_read(3, d);
            checks++; if (d !== exp) begin errors++; $display("FAIL t2_read_ch3: got %h expected %h", d, exp); end
            $display("read ch3: %h", d);
        end
        core_read(3, d);
        exp_underrun[3] = 1'b1;
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL t2_empty_data: got %h expected 0", d); end
        checks++; if (underrun !== exp_underrun) begin errors++; $display("FAIL t2_underrun: got %h expected %h", underrun, exp_underrun); end
        $display("read empty ch3: %h underrun=%h", d, underrun);
    endtask

    task automatic test_full_input();
        logic [31:0] d, exp;
        for (int i = 0; i < 4; i++) push_in(0, $urandom());
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL t3_full_ready: got %b expected 0", in_ready[0]); end
        req_in = 1'b1;
        addr_in = 3'd0;
        in_data[31:0] = 32'hDEAD_BEEF;
        in_valid[0] = 1'b1;
        #1;
        exp = in_q[0].pop_front();
        checks++; if (io_in !== exp) begin errors++; $display("FAIL t3_pop_on_full: got %h expected %h", io_in, exp); end
        $display("pop+push on full ch0: %h", io_in);
        tick();
        req_in = 1'b0;
        in_valid[0] = 1'b0;
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL t3_ready_after_pop: got %b expected 1", in_ready[0]); end
        for (int i = 0; i < 3; i++) begin
            exp = in_q[0].pop_front();
            core_read(0, d);
            checks++; if (d !== exp) begin errors++; $display("FAIL t3_drain: got %h expected %h", d, exp); end
            $display("drain ch0: %h", d);
        end
        core_read(0, d);
        exp_underrun[0] = 1'b1;
        checks++; if (d !== 32'h0 || underrun !== exp_underrun) begin errors++;
            $display("FAIL t3_refused_push: got data=%h udr=%h expected 0 / %h", d, underrun, exp_underrun); end
    endtask

    task automatic test_output();
        logic [31:0] exp;
        out_ready = '0;
        for (int w = 1; w <= 5; w++) write_out(1, 32'(w));
        checks++; if (overrun !== exp_overrun) begin errors++; $display("FAIL t4_overrun: got %h expected %h", overrun, exp_overrun); end
        checks++; if (out_valid !== 8'h02) begin errors++; $display("FAIL t4_valid: got %h expected 02", out_valid); end
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #0;
            exp = out_q[1].pop_front();
            checks++; if (out_data[63:32] !== exp) begin errors++; $display("FAIL t4_deliver: got %h expected %h", out_data[63:32], exp); end
            $display("out ch1: %h", out_data[63:32]);
            tick();
        end
        checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL t4_drained: got %b expected 0", out_valid[1]); end
        out_ready = '0;
    endtask

    task automatic test_write_pop_full();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) write_out(4, 32'(100 + i));
        out_ready[4] = 1'b1;
        out_en = 1'b1;
        addr_out = 3'd4;
        data_out = 32'h9;
        #1;
        exp = out_q[4].pop_front();
        out_q[4].push_back(32'h9);
        checks++; if (out_data[159:128] !== exp) begin errors++; $display("FAIL t4_full_head: got %h expected %h", out_data[159:128], exp); end
        tick();
        out_en = 1'b0;
        checks++; if (overrun !== exp_overrun) begin errors++; $display("FAIL t4_full_wr_pop: got %h expected %h", overrun, exp_overrun); end
        for (int i = 0; i < 4; i++) begin
            exp = out_q[4].pop_front();
            checks++; if (out_data[159:128] !== exp) begin errors++; $display("FAIL t4_full_drain: got %h expected %h", out_data[159:128], exp); end
            $display("out ch4: %h", out_data[159:128]);
            tick();
        end
        out_ready = '0;
    endtask

    task automatic test_interrupt();
        logic [31:0] d, exp;
        itr_mask = 8'h04;
        push_in(2, 32'h2001);
        checks++; if (itr !== 1'b1) begin errors++; $display("FAIL t5_pulse: got %b expected 1", itr); end
        tick();
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL t5_pulse_end: got %b expected 0", itr); end
        push_in(5, 32'h5001);
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL t5_masked: got %b expected 0", itr); end
        exp = in_q[2].pop_front();
        core_read(2, d);
        checks++; if (d !== exp) begin errors++; $display("FAIL t5_read_ch2: got %h expected %h", d, exp); end
        itr_mask = 8'h44;
        in_data[95:64]   = 32'h2002;
        in_data[223:192] = 32'h6001;
        in_valid[2] = 1'b1;
        in_valid[6] = 1'b1;
        in_q[2].push_back(32'h2002);
        in_q[6].push_back(32'h6001);
        tick();
        in_valid = '0;
        checks++; if (itr !== 1'b1) begin errors++; $display("FAIL t5_dual_pulse: got %b expected 1", itr); end
        tick();
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL t5_dual_single: got %b expected 0", itr); end
        push_in(2, 32'h2003);
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL t5_nonempty: got %b expected 0", itr); end
        $display("interrupt checks done itr=%b", itr);
    endtask

    task automatic test_push_pop_empty();
        logic [31:0] d, exp;
        req_in = 1'b1;
        addr_in = 3'd7;
        in_data[255:224] = 32'h77;
        in_valid[7] = 1'b1;
        #1;
        checks++; if (io_in !== 32'h0) begin errors++; $display("FAIL pp_empty_data: got %h expected 0", io_in); end
        tick();
        req_in = 1'b0;
        in_valid[7] = 1'b0;
        exp_underrun[7] = 1'b1;
        in_q[7].push_back(32'h77);
        checks++; if (underrun !== exp_underrun) begin errors++; $display("FAIL pp_underrun: got %h expected %h", underrun, exp_underrun); end
        exp = in_q[7].pop_front();
        core_read(7, d);
        checks++; if (d !== exp) begin errors++; $display("FAIL pp_head: got %h expected %h", d, exp); end
        $display("push+read empty ch7: next head %h", d);
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        for (int k = 0; k < 8; k++) while (in_q[k].size() < 2) push_in(k, $urandom());
        for (int k = 0; k < 8; k++) while (out_q[k].size() < 2) write_out(k, $urandom());
        checks++; if (out_valid !== 8'hFF) begin errors++; $display("FAIL t6_half_full: got %h expected ff", out_valid); end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if ({out_valid, underrun, overrun, in_ready} !== 32'h0 || itr !== 1'b0) begin errors++;
            $display("FAIL t6_async_rst: got ov=%h udr=%h ovr=%h rdy=%h itr=%b expected all 0", out_valid, underrun, overrun, in_ready, itr); end
        @(posedge clk);
        #3 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin in_q[k].delete(); out_q[k].delete(); end
        exp_underrun = '0;
        exp_overrun = '0;
        #1;
        checks++; if (in_ready !== 8'hFF || out_valid !== 8'h00) begin errors++;
            $display("FAIL t6_after_rst: got rdy=%h ov=%h expected ff/00", in_ready, out_valid); end
        core_read(0, d);
        exp_underrun[0] = 1'b1;
        checks++; if (d !== 32'h0 || underrun !== exp_underrun) begin errors++;
            $display("FAIL t6_discarded: got data=%h udr=%h expected 0 / %h", d, underrun, exp_underrun); end
        sts_clr = 1'b1;
        core_read(1, d);
        sts_clr = 1'b0;
        exp_underrun = 8'h02;
        checks++; if (underrun !== exp_underrun) begin errors++; $display("FAIL t6_clr_vs_set: got %h expected %h", underrun, exp_underrun); end
        sts_clr = 1'b1;
        tick();
        sts_clr = 1'b0;
        checks++; if (underrun !== 8'h00) begin errors++; $display("FAIL t6_clr: got %h expected 00", underrun); end
        $display("mid reset and status clear: underrun=%h overrun=%h", underrun, overrun);
    endtask

    initial begin
        rst = 1'b0;
        req_in = 1'b0; addr_in = '0;
        out_en = 1'b0; addr_out = '0; data_out = '0;
        in_data = '0; in_valid = '0;
        out_ready = '0; itr_mask = '0; sts_clr = 1'b0;
        test_reset();
        test_in_flow();
        test_read();
        test_full_input();
        test_output();
        test_write_pop_full();
        test_interrupt();
        test_push_pop_empty();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
